branch_resolve_unit: RTL

Downstream consumer of the fetch-side BTB/BHT/PC-mux stage. Queues each fetch-time prediction, compares it in order against the actual branch outcome from decode, and produces the BTB/BHT feedback (`FedAddress`, `FedToken`) plus a flush/redirect on mispredict. Closes the prediction loop of the fetch unit.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/branch_resolve_unit_if.sv | 34 +++
 rtl/pred_queue.sv | 49 ++++
 rtl/branch_resolve_unit.sv | 109 ++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-side types: prediction record, resolve FSM states, BHT index helper.
package fetch_pkg;

  localparam logic [31:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic        hit;
    logic        taken;
    logic [31:0] target;
  } pred_entry_t;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} bru_state_e;

  // Word index of pc, masked to idx_w bits (pc[idx_w+1:2]); callers narrow to their width.
  function automatic logic [31:0] bht_index(input logic [31:0] pc, input int unsigned idx_w);
    return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Prediction / resolution / feedback bundle between fetch+decode (master) and the resolve unit (slave).
interface branch_resolve_unit_if #(parameter int IDX_W = 6);
  logic             pred_valid;
  logic             pred_ready;
  logic [31:0]      pred_pc;
  logic             pred_hit;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             res_valid;
  logic             res_is_branch;
  logic             res_taken;
  logic [31:0]      res_target;
  logic             fed_valid;
  logic [31:0]      FedAddress;
  logic             FedToken;
  logic [IDX_W-1:0] fed_index;
  logic             flush;
  logic [31:0]      redirect_pc;
  logic             err_underflow;

  modport master (
    output pred_valid, pred_pc, pred_hit, pred_taken, pred_target,
           res_valid, res_is_branch, res_taken, res_target,
    input  pred_ready, fed_valid, FedAddress, FedToken, fed_index,
           flush, redirect_pc, err_underflow
  );

  modport slave (
    input  pred_valid, pred_pc, pred_hit, pred_taken, pred_target,
           res_valid, res_is_branch, res_taken, res_target,
    output pred_ready, fed_valid, FedAddress, FedToken, fed_index,
           flush, redirect_pc, err_underflow
  );
endinterface

// File: rtl/pred_queue.sv
// In-order FIFO of fetch predictions; synchronous clear drops every entry.
module pred_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  pred_entry_t              wdata,
  output pred_entry_t              rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  pred_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves queued fetch predictions against decode outcomes; drives BTB/BHT feedback and flush.
// Optional BRU_PERF_CNT_EN adds perf_branches / perf_mispredicts counters.
module branch_resolve_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_resolve_unit_if.slave bus
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]          perf_branches,
  output logic [31:0]          perf_mispredicts
`endif
);
  bru_state_e             state_q, state_d;
  pred_entry_t            head, wentry;
  logic                   full, empty;
  logic [$clog2(DEPTH):0] count;
  logic                   push, pop, clr;
  logic [31:0]            nxt_pc, expected;
  logic                   mispred, fb, fb_tok;
  logic [31:0]            fb_addr;
  logic [IDX_W-1:0]       fb_idx;
  logic                   unused_taken;

  // Direction is already implied by the predicted target, so the stored bit is informational.
  assign unused_taken = head.taken;

  assign bus.pred_ready = !rst && !full && (state_q == RUN);
  assign push   = bus.pred_valid && bus.pred_ready;
  assign pop    = bus.res_valid && (state_q == RUN) && !empty;
  assign clr    = state_q == FLUSH;
  assign wentry = '{pc: bus.pred_pc, hit: bus.pred_hit, taken: bus.pred_taken, target: bus.pred_target};

  pred_queue #(.DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .clear (clr),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    nxt_pc   = head.pc + PC_INC;
    expected = (bus.res_is_branch && bus.res_taken) ? bus.res_target : nxt_pc;
    mispred  = pop && (head.target != expected);
    // Non-branches that hit in the BTB are trained out with a not-taken token.
    fb       = pop && (bus.res_is_branch || head.hit);
    fb_addr  = bus.res_is_branch ? bus.res_target : nxt_pc;
    fb_tok   = bus.res_is_branch && bus.res_taken;
    fb_idx   = IDX_W'(bht_index(head.pc, IDX_W));
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (mispred) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.fed_valid     <= 1'b0;
      bus.FedAddress    <= '0;
      bus.FedToken      <= 1'b0;
      bus.fed_index     <= '0;
      bus.flush         <= 1'b0;
      bus.redirect_pc   <= '0;
      bus.err_underflow <= 1'b0;
    end else begin
      bus.fed_valid <= fb;
      bus.flush     <= mispred;
      if (fb) begin
        bus.FedAddress <= fb_addr;
        bus.FedToken   <= fb_tok;
        bus.fed_index  <= fb_idx;
      end
      if (mispred) bus.redirect_pc <= expected;
      if (bus.res_valid && (state_q == RUN) && (count == '0)) bus.err_underflow <= 1'b1;
    end
  end

`ifdef BRU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (pop && bus.res_is_branch) perf_branches <= perf_branches + 32'd1;
      if (mispred)                  perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end
`endif
endmodule
